// File: rtl/trap_unit.sv
// Machine-mode trap responder: owns the M-mode trap CSRs and sequences the
// two-cycle redirect/flush that follows a trap entry or MRET at commit.
package trap_pkg;
    typedef enum logic {
        TRAP_ENTER  = 1'b0,
        TRAP_RETURN = 1'b1
    } trap_mode_e;

    typedef struct packed {
        logic        valid;
        trap_mode_e  mode;
        logic [31:0] cause;
        logic [31:0] pc;
        logic [31:0] tval;
    } trap_req_t;
endpackage

module trap_unit
    import trap_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  trap_req_t   trap_req_w,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        flush_req,
    output logic        busy,
    output logic        mie_o
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COMMIT   = 2'd1,
        S_REDIRECT = 2'd2
    } state_e;

    state_e      state, state_nx;
    logic        mie, mpie;
    logic [31:2] mtvec;
    logic [31:2] mepc;
    logic [31:0] mscratch, mcause, mtval;
    logic [31:0] target;

    logic accept_enter, accept_return, csr_wr_en;

    // Requests and CSR writes are only honoured in IDLE; later the source has been flushed.
    always_comb begin
        state_nx       = state;
        accept_enter   = 1'b0;
        accept_return  = 1'b0;
        csr_wr_en      = 1'b0;
        case (state)
            S_IDLE: begin
                csr_wr_en = csr_we;
                if (trap_req_w.valid) begin
                    accept_enter  = (trap_req_w.mode == TRAP_ENTER);
                    accept_return = (trap_req_w.mode == TRAP_RETURN);
                    state_nx      = S_COMMIT;
                end
            end
            S_COMMIT:   state_nx = S_REDIRECT;
            S_REDIRECT: state_nx = S_IDLE;
            default:    state_nx = S_IDLE;
        endcase
    end

    // Trap updates are placed after the CSR write so they win on a same-edge collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= RESET_MTVEC[31:2];
            mepc     <= '0;
            mscratch <= '0;
            mcause   <= '0;
            mtval    <= '0;
            target   <= '0;
        end else begin
            state <= state_nx;
            if (csr_wr_en) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        mie  <= csr_wdata[3];
                        mpie <= csr_wdata[7];
                    end
                    A_MTVEC:    mtvec    <= csr_wdata[31:2];
                    A_MSCRATCH: mscratch <= csr_wdata;
                    A_MEPC:     mepc     <= csr_wdata[31:2];
                    A_MCAUSE:   mcause   <= csr_wdata;
                    A_MTVAL:    mtval    <= csr_wdata;
                    default: ;
                endcase
            end
            if (accept_enter) begin
                mepc   <= trap_req_w.pc[31:2];
                mcause <= trap_req_w.cause;
                mtval  <= trap_req_w.tval;
                mpie   <= mie;
                mie    <= 1'b0;
                target <= {mtvec, 2'b00};
            end else if (accept_return) begin
                mie    <= mpie;
                mpie   <= 1'b1;
                target <= {mepc, 2'b00};
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            A_MSTATUS:  csr_rdata = {19'd0, 2'b11, 3'd0, mpie, 3'd0, mie, 3'd0};
            A_MTVEC:    csr_rdata = {mtvec, 2'b00};
            A_MSCRATCH: csr_rdata = mscratch;
            A_MEPC:     csr_rdata = {mepc, 2'b00};
            A_MCAUSE:   csr_rdata = mcause;
            A_MTVAL:    csr_rdata = mtval;
            default:    csr_rdata = '0;
        endcase
    end

    assign redirect_valid = (state == S_COMMIT);
    assign flush_req      = (state != S_IDLE);
    assign busy           = (state != S_IDLE);
    assign redirect_pc    = (state != S_IDLE) ? target : 32'd0;
    assign mie_o          = mie;
endmodule

// File: doc/trap_unit.md
# trap_unit

Machine-mode trap responder at the commit end of the pipeline. Accepts the `trap_req_t` packet generated upstream (e.g. illegal instruction from decode) once it reaches writeback. Updates the M-mode trap CSRs and drives a two-cycle redirect/flush sequence to the fetch and hazard logic. Also serves `MRET` (`TRAP_RETURN`) and the execute-stage CSR read/write port for the trap CSRs.

## Interface
Parameters:
- `RESET_MTVEC`, default 32'h0000_0000: reset value of `mtvec`.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `trap_req_w`  in  `trap_req_t`  — trap packet at commit:
  - `valid`
  - `mode` (`TRAP_ENTER` or `TRAP_RETURN`)
  - `cause`, `pc`, `tval`
- `csr_we`  in  1  — CSR write strobe from execute.
- `csr_addr`  in  12  — CSR address.
- `csr_wdata`  in  32  — CSR write data, already resolved for RW/RS/RC.
- `csr_rdata`  out  32  — combinational read of `csr_addr`.
- `redirect_valid`  out  1  — fetch must load `redirect_pc` this cycle.
- `redirect_pc`  out  32  — trap vector or return address.
- `flush_req`  out  1  — to the hazard unit; flush F/D/E/M.
- `busy`  out  1  — FSM not IDLE.
- `mie_o`  out  1  — current `mstatus.MIE`.

## Operation
Implemented CSRs and addresses:
- `mstatus` 0x300: bit 3 MIE, bit 7 MPIE; bits 12:11 MPP read as 2'b11 and are not writable; all other bits read 0.
- `mtvec` 0x305: bits 1:0 read 0 (direct mode only); writes to bits 1:0 are ignored.
- `mscratch` 0x340: full 32-bit read/write.
- `mepc` 0x341: bits 1:0 forced to 0 on every write path.
- `mcause` 0x342 and `mtval` 0x343: full 32-bit read/write.
- Any other address: `csr_rdata` = 0; writes are dropped.

FSM states: IDLE, COMMIT, REDIRECT.

IDLE:
- If `trap_req_w.valid` and `mode` = `TRAP_ENTER`, at the edge:
  - `mepc` <= `pc` & ~3
  - `mcause` <= `cause`
  - `mtval` <= `tval`
  - MPIE <= MIE; MIE <= 0
  - latch target = `mtvec` & ~3
  - go to COMMIT.
- If `trap_req_w.valid` and `mode` = `TRAP_RETURN`, at the edge:
  - MIE <= MPIE; MPIE <= 1
  - latch target = `mepc`
  - go to COMMIT.
- Otherwise stay in IDLE.

COMMIT:
- `redirect_valid` = 1, `redirect_pc` = latched target, `flush_req` = 1.
- Go to REDIRECT.

REDIRECT:
- `flush_req` = 1, to drain the instruction fetched in COMMIT; `redirect_valid` = 0.
- Go to IDLE.

Rules:
- `trap_req_w.valid` is ignored in COMMIT and REDIRECT. The flush has invalidated its source.
- If a CSR write and a trap acceptance occur at the same edge, the trap updates win for `mepc`, `mcause`, `mtval` and `mstatus`. A write to any other CSR completes normally.
- CSR writes in COMMIT/REDIRECT are dropped, since the writer is being flushed.
- `csr_rdata` reflects state after the most recent edge; there is no write-to-read bypass.

## Timing
Reset:
- Outputs: `redirect_valid` = 0, `flush_req` = 0, `busy` = 0, `mie_o` = 0, `redirect_pc` = 0; FSM in IDLE.
- CSRs: `mtvec` = `RESET_MTVEC` & ~3; `mepc`, `mcause`, `mtval`, `mscratch` = 0; MIE = MPIE = 0.
- `reset` in COMMIT or REDIRECT aborts the sequence: outputs are deasserted in the next cycle. Any trap CSR updates already taken are overwritten by the reset values.

Trap latency (request valid in cycle N, in IDLE):
- CSRs are visible on `csr_rdata` from N+1.
- `redirect_valid` high for exactly cycle N+1.
- `flush_req` high for cycles N+1 and N+2.
- `busy` high for N+1..N+2.
- The next trap can be accepted in cycle N+3.

Other timing:
- `redirect_pc` holds the latched target during COMMIT and REDIRECT; in IDLE it is 0.
- `busy`, `redirect_valid` and `flush_req` are decoded from registered state only. They have no combinational path from `trap_req_w`.

## Test plan
- Illegal-instruction trap:
  - Stimulus: `mtvec` = 0x0000_0103; request ENTER, cause 2, pc 0x0000_0044, tval 0xFFFF_FFFF.
  - Required: `redirect_valid` for one cycle with `redirect_pc` = 0x0000_0100; `flush_req` for 2 cycles; `mepc` = 0x44, `mcause` = 2, `mtval` = 0xFFFF_FFFF; MIE 1→0 with MPIE = 1.
- MRET:
  - Stimulus: `mepc` = 0x0000_0048, MPIE = 1, MIE = 0; request RETURN.
  - Required: `redirect_pc` = 0x48; MIE = 1, MPIE = 1.
- Same-edge collision:
  - Stimulus: `csr_we` to `mepc` (0x0000_1000) and to `mscratch` (0xA5A5_A5A5) each at the same edge as an ENTER with pc 0x0000_0200.
  - Required: `mepc` = 0x200; `mscratch` = 0xA5A5_A5A5.
- Back-to-back requests:
  - Stimulus: ENTER in cycle N, then `trap_req_w.valid` held high for N+1..N+2 with cause 5.
  - Required: `mcause` unchanged; the second trap is accepted only in N+3.
- Reset mid-sequence:
  - Stimulus: assert `reset` in COMMIT.
  - Required: next cycle `redirect_valid` = `flush_req` = `busy` = 0 and all CSRs at reset values.
- Misaligned pc and unimplemented CSR:
  - Stimulus: ENTER with pc 0x0000_0046; separately, read and write CSR 0x7C0.
  - Required: `mepc` = 0x44; `csr_rdata` = 0 for 0x7C0 and no CSR state changes.
